card_dealer: RTL

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_pkg.sv | 20 ++
 rtl/card_dealer_rank_counter.sv | 25 ++
 rtl/card_dealer.sv | 102 ++++++++++
 3 files changed

// File: rtl/card_pkg.sv
// Shared card codes, dealer state encoding and sizing constants
// for the card dealer block.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_BLANK = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_KING  = 4'd13;

  // Backing store for hand slots; indices past NUM_SLOTS never fill.
  localparam int SLOT_CAP = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAW    = 2'd1,
    ST_PRESENT = 2'd2
  } dealer_state_t;

endpackage

// File: rtl/card_dealer_rank_counter.sv
// Free-running card rank source cycling 1..NUM_RANKS.
// Stands in for a shuffled shoe: the draw instant picks the rank.
module rank_counter
  import card_pkg::*;
#(
  parameter int NUM_RANKS = 13
) (
  input  logic  clk,
  input  logic  resetb,
  output card_t rank
);

  localparam card_t RANK_MAX = card_t'(NUM_RANKS);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      rank <= CARD_ACE;
    end else if (rank >= RANK_MAX) begin
      rank <= CARD_ACE;
    end else begin
      rank <= rank + 4'd1;
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Deals one rank per request into an empty hand slot, presents it
// until acknowledged, and exposes the hand as display-ready codes.
module card_dealer
  import card_pkg::*;
#(
  parameter int NUM_RANKS = 13,
  parameter int NUM_SLOTS = 6
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic [2:0] deal_slot,
  input  logic       card_ack,
  input  logic       clear_hand,
  output logic       card_valid,
  output logic [3:0] card_out,
  output logic       deal_err,
  output logic       busy,
  output logic [3:0] slot0,
  output logic [3:0] slot1,
  output logic [3:0] slot2,
  output logic [3:0] slot3,
  output logic [3:0] slot4,
  output logic [3:0] slot5
);

  localparam logic [3:0] SLOT_LIM = 4'(NUM_SLOTS);

  dealer_state_t state;
  card_t         rank;
  card_t         slots [SLOT_CAP];
  logic [2:0]    tgt;
  logic          slot_ok;
  logic          slot_free;

  rank_counter #(
    .NUM_RANKS(NUM_RANKS)
  ) u_rank (
    .clk   (clk),
    .resetb(resetb),
    .rank  (rank)
  );

  assign slot_ok   = {1'b0, deal_slot} < SLOT_LIM;
  assign slot_free = slots[deal_slot] == CARD_BLANK;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      tgt        <= '0;
      card_out   <= CARD_BLANK;
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
      for (int i = 0; i < SLOT_CAP; i++) slots[i] <= CARD_BLANK;
    end else begin
      deal_err <= 1'b0;
      if (clear_hand) begin
        state      <= ST_IDLE;
        card_valid <= 1'b0;
        for (int i = 0; i < SLOT_CAP; i++) slots[i] <= CARD_BLANK;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (deal_req) begin
              if (slot_ok && slot_free) begin
                tgt   <= deal_slot;
                state <= ST_DRAW;
              end else begin
                deal_err <= 1'b1;
              end
            end
          end
          ST_DRAW: begin
            card_out    <= rank;
            slots[tgt]  <= rank;
            card_valid  <= 1'b1;
            state       <= ST_PRESENT;
          end
          ST_PRESENT: begin
            if (card_ack) begin
              card_valid <= 1'b0;
              state      <= ST_IDLE;
            end
          end
          default: begin
            state      <= ST_IDLE;
            card_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy  = state != ST_IDLE;
  assign slot0 = slots[0];
  assign slot1 = slots[1];
  assign slot2 = slots[2];
  assign slot3 = slots[3];
  assign slot4 = slots[4];
  assign slot5 = slots[5];

endmodule
